// File: rtl/kernel_fdtd_2d_pkg.sv
// Shared types and helpers for the fdtd-2d pipelined multiplier.
// Holds the pipeline stage record, the full-product width helper and the
// overflow / output-bit helpers used by the final stage.
package kernel_fdtd_2d_pkg;

   // Widest full product supported by the stage record.
   // The instantiating block keeps DIN0_WIDTH + DIN1_WIDTH at or below this.
   localparam int unsigned MAX_W = 64;

   // One pipeline stage: valid bit, operand mode and the full product.
   // Bits of product above FULL_W are zero and never inspected.
   typedef struct packed {
      logic             valid;
      logic             is_signed;
      logic [MAX_W-1:0] product;
   } stage_t;

   // Width of the exact product of two operands.
   function automatic int unsigned full_width(input int unsigned w0, input int unsigned w1);
      return w0 + w1;
   endfunction

   // Overflow of a fw-bit product when narrowed to dw bits.
   // Unsigned: any set bit at or above dw.
   // Signed: bits fw-1 .. dw-1 are not all equal.
   function automatic logic calc_ovf(input logic [MAX_W-1:0] p,
                                     input logic             is_signed,
                                     input int unsigned      fw,
                                     input int unsigned      dw);
      logic ovf;
      ovf = 1'b0;
      if (dw < fw) begin
         for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i >= dw && i < fw) begin
               if (is_signed) begin
                  if (p[i] != p[dw-1]) ovf = 1'b1;
               end else begin
                  if (p[i]) ovf = 1'b1;
               end
            end
         end
      end
      return ovf;
   endfunction

   // One bit of the narrowed result. With saturation enabled and an
   // overflow present, the bit comes from the clamp value; otherwise the
   // product is truncated.
   function automatic logic out_bit(input logic [MAX_W-1:0] p,
                                    input logic             is_signed,
                                    input logic             ovf,
                                    input logic             sat_en,
                                    input int unsigned      fw,
                                    input int unsigned      dw,
                                    input int unsigned      idx);
      logic neg;
      neg = is_signed & p[fw-1];
      if (sat_en && ovf) begin
         if (!is_signed) return 1'b1;
         if (idx == dw - 1) return neg;
         return ~neg;
      end
      return p[idx];
   endfunction

endpackage

// File: rtl/kernel_fdtd_2d_mul_stage.sv
// Single enable-gated register stage of the multiplier pipe.
// Cleared asynchronously by ap_rst_n; holds its contents while en is low.
module kernel_fdtd_2d_mul_stage
   import kernel_fdtd_2d_pkg::*;
(
   input  logic   ap_clk,
   input  logic   ap_rst_n,
   input  logic   en,
   input  stage_t d,
   output stage_t q
);

   // Stage register: clear on reset, load only when the pipe advances.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/kernel_fdtd_2d_mul_pipe.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake on both
// sides and an overflow flag for the narrowed result.
// Optional build macro: KERNEL_MUL_PIPE_SAT_EN -- when defined, an
// overflowing result saturates instead of being truncated.
module kernel_fdtd_2d_mul_pipe
   import kernel_fdtd_2d_pkg::*;
#(
   parameter int DIN0_WIDTH = 10,
   parameter int DIN1_WIDTH = 11,
   parameter int DOUT_WIDTH = 20,
   parameter int NUM_STAGE  = 3
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [DIN0_WIDTH-1:0] din0,
   input  logic [DIN1_WIDTH-1:0] din1,
   input  logic                  din_signed,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DOUT_WIDTH-1:0] dout,
   output logic                  dout_ovf
);

   localparam int unsigned FULL_W = full_width(DIN0_WIDTH, DIN1_WIDTH);

`ifdef KERNEL_MUL_PIPE_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   logic              en;
   logic [FULL_W-1:0] a_full;
   logic [FULL_W-1:0] b_full;
   logic [FULL_W-1:0] prod_full;
   stage_t            stage_in;
   stage_t            stage_q [NUM_STAGE];
   stage_t            last;

   // Extend both operands to the full product width according to mode;
   // the low FULL_W bits of the product are then exact in either mode.
   assign a_full    = {{DIN1_WIDTH{din_signed & din0[DIN0_WIDTH-1]}}, din0};
   assign b_full    = {{DIN0_WIDTH{din_signed & din1[DIN1_WIDTH-1]}}, din1};
   assign prod_full = a_full * b_full;

   // Record entering stage 0; a bubble enters whenever din_valid is low.
   always_comb begin
      stage_in           = '0;
      stage_in.valid     = din_valid;
      stage_in.is_signed = din_signed;
      stage_in.product   = MAX_W'(prod_full);
   end

   // Chain of NUM_STAGE register stages sharing one advance enable.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGE; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            kernel_fdtd_2d_mul_stage u_stage (
               .ap_clk   (ap_clk),
               .ap_rst_n (ap_rst_n),
               .en       (en),
               .d        (stage_in),
               .q        (stage_q[gi])
            );
         end else begin : g_next
            kernel_fdtd_2d_mul_stage u_stage (
               .ap_clk   (ap_clk),
               .ap_rst_n (ap_rst_n),
               .en       (en),
               .d        (stage_q[gi-1]),
               .q        (stage_q[gi])
            );
         end
      end
   endgenerate

   assign last = stage_q[NUM_STAGE-1];

   // The whole pipe moves when the output slot is empty or being consumed,
   // so accept and emit can happen in the same cycle.
   assign dout_valid = last.valid;
   assign en         = dout_ready | ~dout_valid;
   assign din_ready  = en;

   // Overflow and the narrowed result are derived from the final stage, so
   // they stay stable for as long as that stage is frozen.
   assign dout_ovf = calc_ovf(last.product, last.is_signed, FULL_W, DOUT_WIDTH);

   generate
      for (gi = 0; gi < DOUT_WIDTH; gi++) begin : g_dout
         assign dout[gi] = out_bit(last.product, last.is_signed, dout_ovf, SAT_EN,
                                   FULL_W, DOUT_WIDTH, gi);
      end
   endgenerate

endmodule

// File: tb/tb_kernel_fdtd_2d_mul_pipe.sv
// Self-checking bench for kernel_fdtd_2d_mul_pipe (default parameters).
// Honours KERNEL_MUL_PIPE_SAT_EN when choosing expected results.
module tb_kernel_fdtd_2d_mul_pipe;

   localparam int W0 = 10;
   localparam int W1 = 11;
   localparam int WO = 20;
   localparam int NS = 3;

`ifdef KERNEL_MUL_PIPE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          din_valid = 1'b0;
   logic          din_ready;
   logic [W0-1:0] din0 = '0;
   logic [W1-1:0] din1 = '0;
   logic          din_signed = 1'b0;
   logic          dout_valid;
   logic          dout_ready = 1'b1;
   logic [WO-1:0] dout;
   logic          dout_ovf;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [WO:0] exp_q[$];
   logic [WO:0] got_q[$];
   int          acc_q[$];
   int          emit_q[$];
   logic [WO-1:0] mon_d;
   logic          mon_o;

   kernel_fdtd_2d_mul_pipe #(
      .DIN0_WIDTH (W0),
      .DIN1_WIDTH (W1),
      .DOUT_WIDTH (WO),
      .NUM_STAGE  (NS)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .din0       (din0),
      .din1       (din1),
      .din_signed (din_signed),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout       (dout),
      .dout_ovf   (dout_ovf)
   );

   always #5 ap_clk = ~ap_clk;

   always @(posedge ap_clk) cyc <= cyc + 1;

   // Reference: exact integer product, range test, then clamp or wrap.
   function automatic void model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                 input logic s, output logic [WO-1:0] d, output logic o);
      longint av, bv, p;
      av = s ? longint'($signed(a)) : longint'(a);
      bv = s ? longint'($signed(b)) : longint'(b);
      p  = av * bv;
      if (s) o = (p > 64'sd524287) || (p < -64'sd524288);
      else   o = (p > 64'sd1048575);
      if (SAT && o) begin
         if (!s)        d = 20'hFFFFF;
         else if (p < 0) d = 20'h80000;
         else           d = 20'h7FFFF;
      end else begin
         d = p[WO-1:0];
      end
   endfunction

   // Collector: records every accepted operand pair and every emitted result.
   always @(negedge ap_clk) begin
      if (ap_rst_n) begin
         if (din_valid && din_ready) begin
            model(din0, din1, din_signed, mon_d, mon_o);
            exp_q.push_back({mon_o, mon_d});
            acc_q.push_back(cyc);
         end
         if (dout_valid && dout_ready) begin
            got_q.push_back({dout_ovf, dout});
            emit_q.push_back(cyc);
         end
      end
   end

   task automatic clear_q();
      exp_q.delete(); got_q.delete(); acc_q.delete(); emit_q.delete();
   endtask

   // Present one operand pair and hold it until it is accepted.
   task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b, input logic s);
      bit acc;
      int n;
      din_valid = 1'b1; din0 = a; din1 = b; din_signed = s;
      n = 0;
      do begin
         @(negedge ap_clk);
         acc = din_ready;
         @(posedge ap_clk); #1;
         n++;
      end while (!acc && n < 100);
      din_valid = 1'b0;
   endtask

   task automatic wait_count(input int n, output bit timeout);
      int k;
      k = 0;
      while (got_q.size() < n && k < 300) begin
         @(posedge ap_clk); #1;
         k++;
      end
      timeout = (got_q.size() < n);
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0;
      #12;
      tests_run++;
      if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
      tests_run++;
      if (dout !== '0) begin tests_failed++; $display("FAIL reset_dout: got %h want 0", dout); end
      tests_run++;
      if (dout_ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", dout_ovf); end
      @(posedge ap_clk); #1;
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      tests_run++;
      if (din_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_din_ready: got %b want 1", din_ready); end
      @(posedge ap_clk); #1;
      $display("[TB] reset checked");
   endtask

   task automatic test_unsigned_basic();
      bit to;
      clear_q();
      send(10'd3, 11'd5, 1'b0);
      wait_count(1, to);
      tests_run++;
      if (to) begin
         tests_failed++; $display("FAIL ubasic_timeout: got %0d results want 1", got_q.size());
      end else begin
         $display("[TB] ubasic 3*5 -> dout=%h ovf=%b lat=%0d", got_q[0][WO-1:0], got_q[0][WO], emit_q[0]-acc_q[0]);
         tests_run++;
         if (got_q[0][WO-1:0] !== 20'd15) begin tests_failed++; $display("FAIL ubasic_dout: got %h want %h", got_q[0][WO-1:0], 20'd15); end
         tests_run++;
         if (got_q[0][WO] !== 1'b0) begin tests_failed++; $display("FAIL ubasic_ovf: got %b want 0", got_q[0][WO]); end
         tests_run++;
         if (emit_q[0] - acc_q[0] !== NS) begin tests_failed++; $display("FAIL ubasic_latency: got %0d want %0d", emit_q[0]-acc_q[0], NS); end
      end
   endtask

   task automatic test_unsigned_ovf();
      bit to;
      logic [WO-1:0] want;
      want = SAT ? 20'hFFFFF : 20'hFF401;
      clear_q();
      send(10'd1023, 11'd2047, 1'b0);
      wait_count(1, to);
      tests_run++;
      if (to) begin
         tests_failed++; $display("FAIL uovf_timeout: got %0d results want 1", got_q.size());
      end else begin
         $display("[TB] uovf 1023*2047 -> dout=%h ovf=%b", got_q[0][WO-1:0], got_q[0][WO]);
         tests_run++;
         if (got_q[0][WO-1:0] !== want) begin tests_failed++; $display("FAIL uovf_dout: got %h want %h", got_q[0][WO-1:0], want); end
         tests_run++;
         if (got_q[0][WO] !== 1'b1) begin tests_failed++; $display("FAIL uovf_ovf: got %b want 1", got_q[0][WO]); end
      end
   endtask

   task automatic test_signed();
      bit to;
      logic [WO-1:0] want_b;
      want_b = SAT ? 20'h7FFFF : 20'h80000;
      clear_q();
      send(10'h3FF, 11'd5, 1'b1);
      send(10'h200, 11'h400, 1'b1);
      wait_count(2, to);
      tests_run++;
      if (to) begin
         tests_failed++; $display("FAIL signed_timeout: got %0d results want 2", got_q.size());
      end else begin
         $display("[TB] signed A -> dout=%h ovf=%b", got_q[0][WO-1:0], got_q[0][WO]);
         $display("[TB] signed B -> dout=%h ovf=%b", got_q[1][WO-1:0], got_q[1][WO]);
         tests_run++;
         if (got_q[0] !== {1'b0, 20'hFFFFB}) begin tests_failed++; $display("FAIL signed_a: got %h want %h", got_q[0], {1'b0, 20'hFFFFB}); end
         tests_run++;
         if (got_q[1] !== {1'b1, want_b}) begin tests_failed++; $display("FAIL signed_b: got %h want %h", got_q[1], {1'b1, want_b}); end
      end
   endtask

   task automatic test_backpressure();
      bit to;
      clear_q();
      dout_ready = 1'b1;
      fork
         begin
            for (int i = 1; i <= 6; i++) send(W0'(i), 11'd2, 1'b0);
         end
         begin
            int k;
            logic [WO:0] held;
            k = 0;
            while (!dout_valid && k < 50) begin @(posedge ap_clk); #1; k++; end
            dout_ready = 1'b0;
            held = {dout_ovf, dout};
            for (int c = 0; c < 4; c++) begin
               @(negedge ap_clk);
               tests_run++;
               if (din_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_din_ready c%0d: got %b want 0", c, din_ready); end
               tests_run++;
               if (dout_valid !== 1'b1 || {dout_ovf, dout} !== held) begin
                  tests_failed++; $display("FAIL bp_hold c%0d: got v=%b %h want v=1 %h", c, dout_valid, {dout_ovf, dout}, held);
               end
            end
            @(posedge ap_clk); #1;
            dout_ready = 1'b1;
         end
      join
      wait_count(6, to);
      tests_run++;
      if (to || got_q.size() != 6) begin
         tests_failed++; $display("FAIL bp_count: got %0d results want 6", got_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            $display("[TB] bp result %0d -> %0d", i, got_q[i][WO-1:0]);
            tests_run++;
            if (got_q[i] !== {1'b0, WO'(2*(i+1))}) begin
               tests_failed++; $display("FAIL bp_result%0d: got %h want %h", i, got_q[i], {1'b0, WO'(2*(i+1))});
            end
         end
      end
   endtask

   task automatic test_mixed_throughput();
      bit to;
      clear_q();
      dout_ready = 1'b1;
      for (int i = 0; i < 24; i++) send(W0'($urandom), W1'($urandom), 1'(i % 2));
      wait_count(24, to);
      tests_run++;
      if (to) begin
         tests_failed++; $display("FAIL mixed_timeout: got %0d results want 24", got_q.size());
      end else begin
         for (int i = 0; i < 24; i++) begin
            $display("[TB] mixed %0d -> %h (model %h) lat=%0d", i, got_q[i], exp_q[i], emit_q[i]-acc_q[i]);
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL mixed_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
            tests_run++;
            if (emit_q[i] - acc_q[i] !== NS) begin tests_failed++; $display("FAIL mixed_latency%0d: got %0d want %0d", i, emit_q[i]-acc_q[i], NS); end
         end
         tests_run++;
         if (emit_q[23] - emit_q[0] !== 23) begin tests_failed++; $display("FAIL mixed_throughput: got span %0d want 23", emit_q[23]-emit_q[0]); end
      end
   endtask

   task automatic test_random_backpressure();
      bit to;
      bit drv_done;
      clear_q();
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 30; i++) send(W0'($urandom), W1'($urandom), 1'($urandom));
            drv_done = 1'b1;
         end
         begin
            int k;
            k = 0;
            while (!drv_done && k < 2000) begin
               @(posedge ap_clk); #1;
               dout_ready = 1'($urandom);
               k++;
            end
         end
      join
      dout_ready = 1'b1;
      wait_count(30, to);
      repeat (5) @(posedge ap_clk);
      #1;
      tests_run++;
      if (got_q.size() != 30 || exp_q.size() != 30) begin
         tests_failed++; $display("FAIL rbp_count: got %0d results want 30", got_q.size());
      end else begin
         for (int i = 0; i < 30; i++) begin
            $display("[TB] rbp %0d -> %h (model %h)", i, got_q[i], exp_q[i]);
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL rbp_result%0d: got %h want %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_midflight();
      bit to;
      clear_q();
      dout_ready = 1'b1;
      send(10'd11, 11'd3, 1'b0);
      send(10'd12, 11'd3, 1'b0);
      send(10'd13, 11'd3, 1'b0);
      tests_run++;
      if (dout_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_valid: got %b want 1", dout_valid); end
      #2;
      ap_rst_n = 1'b0;
      #1;
      tests_run++;
      if (dout_valid !== 1'b0 || dout !== '0) begin
         tests_failed++; $display("FAIL rmid_async: got v=%b d=%h want v=0 d=0", dout_valid, dout);
      end
      @(posedge ap_clk); #1;
      clear_q();
      ap_rst_n = 1'b1;
      repeat (8) @(posedge ap_clk);
      #1;
      tests_run++;
      if (got_q.size() != 0 || dout_valid !== 1'b0) begin
         tests_failed++; $display("FAIL rmid_stale: got %0d results v=%b want 0 v=0", got_q.size(), dout_valid);
      end
      send(10'd7, 11'd9, 1'b1);
      wait_count(1, to);
      tests_run++;
      if (to) begin
         tests_failed++; $display("FAIL rmid_timeout: got %0d results want 1", got_q.size());
      end else begin
         $display("[TB] rmid after reset 7*9 -> %h lat=%0d", got_q[0], emit_q[0]-acc_q[0]);
         tests_run++;
         if (got_q[0] !== {1'b0, 20'd63}) begin tests_failed++; $display("FAIL rmid_result: got %h want %h", got_q[0], {1'b0, 20'd63}); end
         tests_run++;
         if (emit_q[0] - acc_q[0] !== NS) begin tests_failed++; $display("FAIL rmid_latency: got %0d want %0d", emit_q[0]-acc_q[0], NS); end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_unsigned_ovf();
      test_signed();
      test_backpressure();
      test_mixed_throughput();
      test_random_backpressure();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
